mealy_seq_detector: RTL and testbench

- Parametrised Mealy serial-pattern detector. Generalises the fixed two-state "11" detector to any PAT_W-bit pattern, with selectable overlap mode, an input qualifier and a saturating match counter.
- Sits on a 1-bit serial stream in the lab datapath.
- `match` is combinational from the current input and the registered state (Mealy). The counter and the debug state are registered.

---
 rtl/mealy_pkg.sv | 62 ++++++
 rtl/mealy_seq_detector_if.sv | 21 ++
 rtl/sat_counter.sv | 29 ++
 rtl/mealy_seq_detector.sv | 77 +++++++
 tb/tb_mealy_seq_detector.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/mealy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mealy_pkg
//  Description : Elaboration-time helpers for the serial pattern detector.
//  Revision    : 1.0  initial release
// ============================================================================
package mealy_pkg;

    localparam int c_MAX_PAT_W = 16;

    // Prefix-length register width: $clog2(pat_w), never below 1.
    function automatic int state_width(input int pat_w);
        return (pat_w <= 2) ? 1 : $clog2(pat_w);
    endfunction

    // Bit i of the pattern in arrival order (i = 0 is the first bit received).
    function automatic bit pat_bit(input logic [c_MAX_PAT_W-1:0] pattern,
                                   input int width, input int i);
        return pattern[width-1-i];
    endfunction

    // Longest proper border of the first n pattern bits.
    function automatic int border_len(input logic [c_MAX_PAT_W-1:0] pattern,
                                      input int width, input int n);
        int  result;
        bit  ok;
        result = 0;
        for (int l = 1; l < n; l++) begin
            ok = 1'b1;
            for (int i = 0; i < l; i++)
                if (pat_bit(pattern, width, i) != pat_bit(pattern, width, n-l+i))
                    ok = 1'b0;
            if (ok)
                result = l;
        end
        return result;
    endfunction

    // Longest pattern prefix that is a suffix of (first k pattern bits, then b).
    // Returns width exactly when the full pattern has just been seen.
    function automatic int next_prefix(input logic [c_MAX_PAT_W-1:0] pattern,
                                       input int width, input int k, input int b);
        int  result;
        bit  ok;
        bit  sbit;
        result = 0;
        for (int l = 1; l <= k + 1 && l <= width; l++) begin
            ok = 1'b1;
            for (int i = 0; i < l; i++) begin
                sbit = ((k + 1 - l + i) < k) ? pat_bit(pattern, width, k + 1 - l + i)
                                             : bit'(b);
                if (pat_bit(pattern, width, i) != sbit)
                    ok = 1'b0;
            end
            if (ok)
                result = l;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mealy_seq_detector_if.sv
`default_nettype none
// ============================================================================
//  Module      : mealy_seq_detector_if
//  Description : Serial stream in, match / count / debug state out.
//  Revision    : 1.0  initial release
// ============================================================================
interface mealy_seq_detector_if #(
    parameter int CNT_W   = 8,
    parameter int STATE_W = 2
);
    logic               in;
    logic               in_valid;
    logic               clr;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic [STATE_W-1:0] state_o;

    modport master (output in, in_valid, clr, input match, match_count, state_o);
    modport slave  (input in, in_valid, clr, output match, match_count, state_o);
endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Saturating up-counter with synchronous clear.
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  wire logic             clk,
    input  wire logic             areset,
    input  wire logic             inc,
    input  wire logic             clr,
    output logic      [CNT_W-1:0] q
);
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or posedge areset) begin
        if (areset)
            count_q <= '0;
        else if (clr)
            count_q <= '0;
        else if (inc && (count_q != {CNT_W{1'b1}}))
            count_q <= count_q + 1'b1;
    end

    assign q = count_q;
endmodule
`default_nettype wire

// File: rtl/mealy_seq_detector.sv
`default_nettype none
// ============================================================================
//  Module      : mealy_seq_detector
//  Description : Parametrised Mealy serial-pattern detector, table driven.
//  Revision    : 1.0  initial release
// ============================================================================
module mealy_seq_detector
    import mealy_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
    parameter int               OVERLAP = 1,
    parameter int               CNT_W   = 8
) (
    input wire logic             clk,
    input wire logic             areset,
    mealy_seq_detector_if.slave  bus
);
    localparam int c_STATE_W = state_width(PAT_W);
    localparam int c_N_ST    = 2 ** c_STATE_W;

    if (PAT_W < 2 || PAT_W > c_MAX_PAT_W) begin : g_bad_pat_w
        $error("mealy_seq_detector: PAT_W must lie in 2..16");
    end

    logic [c_N_ST*2-1:0]                w_hit_tab;
    logic [c_N_ST*2-1:0][c_STATE_W-1:0] w_nxt_tab;
    logic [c_STATE_W:0]                 w_sel;
    logic                               w_match;
    logic [c_STATE_W-1:0]               state_q;
    logic [c_STATE_W-1:0]               state_d;

    // Lookup indexed by {state, bit}; unreachable states map to 0 with no hit.
    for (genvar k = 0; k < c_N_ST; k++) begin : g_state
        for (genvar b = 0; b < 2; b++) begin : g_bit
            localparam int RAW = (k < PAT_W)
                               ? next_prefix(16'(PATTERN), PAT_W, k, b) : 0;
            localparam bit HIT = (RAW == PAT_W);
            localparam int NXT = HIT ? ((OVERLAP != 0)
                               ? border_len(16'(PATTERN), PAT_W, PAT_W) : 0) : RAW;
            assign w_hit_tab[k*2+b] = HIT;
            assign w_nxt_tab[k*2+b] = c_STATE_W'(NXT);
        end
    end

    assign w_sel   = {state_q, bus.in};
    assign w_match = ~areset & bus.in_valid & w_hit_tab[w_sel];

    always_comb begin
        state_d = state_q;
        if (bus.clr)
            state_d = '0;
        else if (bus.in_valid)
            state_d = w_nxt_tab[w_sel];
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset)
            state_q <= '0;
        else
            state_q <= state_d;
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk    (clk),
        .areset (areset),
        .inc    (w_match),
        .clr    (bus.clr),
        .q      (bus.match_count)
    );

    assign bus.match   = w_match;
    assign bus.state_o = state_q;
endmodule
`default_nettype wire

// File: tb/tb_mealy_seq_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mealy_seq_detector
//  Description : Scoreboard bench for three detector configurations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mealy_seq_detector;

    typedef struct {
        bit m;
        int st;
        int cnt;
    } exp_t;

    logic clk;
    logic rst_a, rst_b, rst_c;
    int   n_vec;
    int   n_err;

    exp_t qa[$], qb[$], qc[$];

    mealy_seq_detector_if #(.CNT_W(8), .STATE_W(2)) ifa ();
    mealy_seq_detector_if #(.CNT_W(8), .STATE_W(2)) ifb ();
    mealy_seq_detector_if #(.CNT_W(2), .STATE_W(1)) ifc ();

    mealy_seq_detector #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1), .CNT_W(8)) u_dut_a (
        .clk(clk), .areset(rst_a), .bus(ifa.slave));
    mealy_seq_detector #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(0), .CNT_W(8)) u_dut_b (
        .clk(clk), .areset(rst_b), .bus(ifb.slave));
    mealy_seq_detector #(.PAT_W(2), .PATTERN(2'b11), .OVERLAP(1), .CNT_W(2)) u_dut_c (
        .clk(clk), .areset(rst_c), .bus(ifc.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle_all();
        ifa.in_valid = 1'b0; ifa.clr = 1'b0;
        ifb.in_valid = 1'b0; ifb.clr = 1'b0;
        ifc.in_valid = 1'b0; ifc.clr = 1'b0;
    endtask

    // Apply one vector to DUT d for one clock and queue its expected response.
    task automatic drive(input int d, input bit b, input bit v, input bit c,
                         input bit m, input int st, input int cnt);
        exp_t e;
        e.m = m; e.st = st; e.cnt = cnt;
        @(posedge clk); #1;
        idle_all();
        case (d)
            0:       begin ifa.in = b; ifa.in_valid = v; ifa.clr = c; qa.push_back(e); end
            1:       begin ifb.in = b; ifb.in_valid = v; ifb.clr = c; qb.push_back(e); end
            default: begin ifc.in = b; ifc.in_valid = v; ifc.clr = c; qc.push_back(e); end
        endcase
    endtask

    // Monitor: match sampled mid-cycle, registered outputs just after the edge.
    initial begin
        exp_t ea, eb, ec;
        bit   ha, hb, hc;
        bit   ma, mb, mc;
        forever begin
            @(negedge clk);
            ha = (qa.size() > 0); hb = (qb.size() > 0); hc = (qc.size() > 0);
            if (ha) begin ea = qa.pop_front(); ma = ifa.match; end
            if (hb) begin eb = qb.pop_front(); mb = ifb.match; end
            if (hc) begin ec = qc.pop_front(); mc = ifc.match; end
            @(posedge clk); #1;
            if (ha) begin
                chk("A match", int'(ma), int'(ea.m));
                chk("A state", int'(ifa.state_o), ea.st);
                chk("A count", int'(ifa.match_count), ea.cnt);
            end
            if (hb) begin
                chk("B match", int'(mb), int'(eb.m));
                chk("B state", int'(ifb.state_o), eb.st);
                chk("B count", int'(ifb.match_count), eb.cnt);
            end
            if (hc) begin
                chk("C match", int'(mc), int'(ec.m));
                chk("C state", int'(ifc.state_o), ec.st);
                chk("C count", int'(ifc.match_count), ec.cnt);
            end
        end
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        ifa.in = 1'b0; ifb.in = 1'b0; ifc.in = 1'b0;
        idle_all();
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        #1;
        chk("reset A state", int'(ifa.state_o), 0);
        chk("reset A count", int'(ifa.match_count), 0);
        chk("reset B state", int'(ifb.state_o), 0);
        chk("reset B count", int'(ifb.match_count), 0);
        chk("reset C state", int'(ifc.state_o), 0);
        chk("reset C count", int'(ifc.match_count), 0);

        // 1101 with overlap: stream 1,1,0,1,1,0,1
        drive(0, 1, 1, 0, 0, 1, 0);
        drive(0, 1, 1, 0, 0, 2, 0);
        drive(0, 0, 1, 0, 0, 3, 0);
        drive(0, 1, 1, 0, 1, 1, 1);
        drive(0, 1, 1, 0, 0, 2, 1);
        drive(0, 0, 1, 0, 0, 3, 1);
        drive(0, 1, 1, 0, 1, 1, 2);

        // 1101 without overlap: same stream
        drive(1, 1, 1, 0, 0, 1, 0);
        drive(1, 1, 1, 0, 0, 2, 0);
        drive(1, 0, 1, 0, 0, 3, 0);
        drive(1, 1, 1, 0, 1, 0, 1);
        drive(1, 1, 1, 0, 0, 1, 1);
        drive(1, 0, 1, 0, 0, 0, 1);
        drive(1, 1, 1, 0, 0, 1, 1);

        // 11 with overlap: stream 0,1,1,1,0,1
        drive(2, 0, 1, 0, 0, 0, 0);
        drive(2, 1, 1, 0, 0, 1, 0);
        drive(2, 1, 1, 0, 1, 1, 1);
        drive(2, 1, 1, 0, 1, 1, 2);
        drive(2, 0, 1, 0, 0, 0, 2);
        drive(2, 1, 1, 0, 0, 1, 2);

        // 2-bit counter saturation after a clear
        drive(2, 0, 0, 1, 0, 0, 0);
        drive(2, 1, 1, 0, 0, 1, 0);
        drive(2, 1, 1, 0, 1, 1, 1);
        drive(2, 1, 1, 0, 1, 1, 2);
        drive(2, 1, 1, 0, 1, 1, 3);
        drive(2, 1, 1, 0, 1, 1, 3);
        drive(2, 1, 1, 0, 1, 1, 3);

        // Qualifier gaps: invalid bits carry values that would disturb the state
        drive(0, 0, 0, 1, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        drive(0, 1, 1, 0, 0, 2, 0);
        drive(0, 0, 0, 0, 0, 2, 0);
        drive(0, 0, 1, 0, 0, 3, 0);
        drive(0, 1, 1, 0, 1, 1, 1);

        // Asynchronous reset mid-pattern, between clock edges
        drive(0, 1, 1, 0, 0, 2, 1);
        drive(0, 0, 1, 0, 0, 3, 1);
        @(posedge clk); #1;
        idle_all();
        ifa.in = 1'b1; ifa.in_valid = 1'b1;
        #1;
        chk("A match before areset", int'(ifa.match), 1);
        rst_a = 1'b1;
        #1;
        chk("A match during areset", int'(ifa.match), 0);
        chk("A state on areset", int'(ifa.state_o), 0);
        chk("A count on areset", int'(ifa.match_count), 0);
        #1;
        rst_a = 1'b0;
        ifa.in_valid = 1'b0;
        drive(0, 1, 1, 0, 0, 1, 0);
        drive(0, 1, 1, 0, 0, 2, 0);
        drive(0, 1, 1, 0, 0, 2, 0);
        drive(0, 0, 1, 0, 0, 3, 0);
        drive(0, 1, 1, 0, 1, 1, 1);

        // clr in the matching cycle: match still seen, bit not counted
        drive(0, 1, 1, 0, 0, 2, 1);
        drive(0, 0, 1, 0, 0, 3, 1);
        drive(0, 1, 1, 1, 1, 0, 0);
        drive(0, 1, 1, 0, 0, 1, 0);

        @(posedge clk); #1;
        idle_all();
        for (int i = 0; i < 10 && (qa.size() + qb.size() + qc.size()) > 0; i++)
            @(posedge clk);
        @(posedge clk); #3;
        if ((qa.size() + qb.size() + qc.size()) > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0",
                     qa.size() + qb.size() + qc.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
